// File: rtl/fir_ss_feeder_if.sv
// Valid/ready sample link (AXI-Stream subset) used on both sides of fir_ss_feeder.
interface fir_ss_feeder_if #(
  parameter int pDATA_WIDTH = 32
);
  logic                   tvalid;
  logic                   tready;
  logic [pDATA_WIDTH-1:0] tdata;
  logic                   tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/fir_ss_feeder.sv
// FWFT input FIFO in front of the FIR ss_* sink; counts samples against data_length and forces tlast.
// Optional stall statistics counter enabled by defining FIR_SS_FEEDER_STATS_EN.
module fir_ss_feeder #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 8
) (
  input  logic                     axis_clk,
  input  logic                     axis_rst,
  fir_ss_feeder_if.slave           s,
  fir_ss_feeder_if.master          ss,
  input  logic                     ap_start,
  input  logic [31:0]              data_length,
  output logic                     frame_done,
  output logic                     busy,
  output logic [$clog2(pDEPTH):0]  level,
  output logic                     err_early_last,
  output logic                     err_missing_last,
  output logic [31:0]              stall_cnt
);
  localparam int AW = $clog2(pDEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [AW:0]          wr_ptr_q, rd_ptr_q, level_d;
  logic                 full_q, empty_q;
  logic [pDATA_WIDTH:0] mem_q [pDEPTH];
  logic [pDATA_WIDTH:0] head;
  logic [31:0]          len_q, len_d, count_q, count_d;
  logic                 err_early_q, err_early_d, err_miss_q, err_miss_d;
  logic                 done_q, done_d;
  logic                 push, pop, at_final, tlast_f;

  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign ss.tvalid = !empty_q;
  assign ss.tdata  = empty_q ? '0 : head[pDATA_WIDTH-1:0];
  assign ss.tlast  = !empty_q && head[pDATA_WIDTH];

  // NOTE: full_q is registered, so a pop in the same cycle does not reopen s.tready.
  assign s.tready  = (state_q == STREAM) && !full_q;
  assign push      = s.tvalid && s.tready;
  assign pop       = !empty_q && ss.tready;
  assign at_final  = (count_q == len_q - 32'd1);
  assign tlast_f   = at_final || s.tlast;

  assign level     = wr_ptr_q - rd_ptr_q;
  assign level_d   = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  assign frame_done       = done_q;
  assign busy             = (state_q != IDLE);
  assign err_early_last   = err_early_q;
  assign err_missing_last = err_miss_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    err_early_d = err_early_q;
    err_miss_d  = err_miss_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ap_start) begin
          len_d       = data_length;
          count_d     = '0;
          err_early_d = 1'b0;
          err_miss_d  = 1'b0;
          // An empty frame completes immediately without touching the FIFO.
          if (data_length == 32'd0) done_d  = 1'b1;
          else                      state_d = STREAM;
        end
      end
      STREAM: begin
        if (push) begin
          count_d = count_q + 32'd1;
          if (s.tlast && !at_final) err_early_d = 1'b1;
          if (at_final && !s.tlast) err_miss_d  = 1'b1;
          if (tlast_f)              state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && ss.tlast) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      count_q     <= '0;
      err_early_q <= 1'b0;
      err_miss_q  <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      err_early_q <= err_early_d;
      err_miss_q  <= err_miss_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_q    <= rd_ptr_q + {{AW{1'b0}}, pop};
      full_q      <= (level_d == (AW+1)'(pDEPTH));
      empty_q     <= (level_d == '0);
    end
  end

  // NOTE: storage is not reset; resetting the pointers discards it and ss.tdata is masked while empty.
  always_ff @(posedge axis_clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {tlast_f, s.tdata};
  end

`ifdef FIR_SS_FEEDER_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge axis_clk) begin
    if (axis_rst)                                   stall_q <= '0;
    else if (state_q == IDLE && ap_start)           stall_q <= '0;
    else if (ss.tvalid && !ss.tready && stall_q != '1) stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fir_ss_feeder.sv
// Self-checking bench for fir_ss_feeder: table-driven frames, corner-case sequences, random frames vs. a frame-level model.
`timescale 1ns/1ps
module tb_fir_ss_feeder;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef FIR_SS_FEEDER_STATS_EN
  localparam int EXP_STALL = 7;
`else
  localparam int EXP_STALL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ap_start;
  logic [31:0]   data_length;
  logic          frame_done, busy, err_early_last, err_missing_last;
  logic [LW-1:0] level;
  logic [31:0]   stall_cnt;

  fir_ss_feeder_if #(.pDATA_WIDTH(DW)) s_if ();
  fir_ss_feeder_if #(.pDATA_WIDTH(DW)) ss_if ();

  fir_ss_feeder #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH)) dut (
    .axis_clk         (clk),
    .axis_rst         (rst),
    .s                (s_if),
    .ss               (ss_if),
    .ap_start         (ap_start),
    .data_length      (data_length),
    .frame_done       (frame_done),
    .busy             (busy),
    .level            (level),
    .err_early_last   (err_early_last),
    .err_missing_last (err_missing_last),
    .stall_cnt        (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Passive monitor of accepted output words and frame_done pulses.
  logic [DW:0] mon_q[$];
  int          done_cnt = 0;
  always @(negedge clk) begin
    if (ss_if.tvalid && ss_if.tready) mon_q.push_back({ss_if.tlast, ss_if.tdata});
    if (frame_done) done_cnt++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic step_push(output bit pushed);
    @(negedge clk);
    pushed = s_if.tvalid && s_if.tready;
    @(posedge clk); #1;
  endtask

  task automatic start(input int len);
    ap_start    = 1'b1;
    data_length = 32'(len);
    step();
    ap_start    = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_s_tready"},  64'(s_if.tready),      64'd0);
    check({tag, "_ss_tvalid"}, 64'(ss_if.tvalid),     64'd0);
    check({tag, "_ss_tdata"},  64'(ss_if.tdata),      64'd0);
    check({tag, "_ss_tlast"},  64'(ss_if.tlast),      64'd0);
    check({tag, "_done"},      64'(frame_done),       64'd0);
    check({tag, "_busy"},      64'(busy),             64'd0);
    check({tag, "_level"},     64'(level),            64'd0);
    check({tag, "_err_early"}, 64'(err_early_last),   64'd0);
    check({tag, "_err_miss"},  64'(err_missing_last), 64'd0);
    check({tag, "_stall"},     64'(stall_cnt),        64'd0);
  endtask

  task automatic wait_done(input string tag, input int budget, input int base);
    int c = 0;
    while (done_cnt == base && c < budget) begin
      step();
      c++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt - base), 64'd1);
  endtask

  // Frame-level reference: which samples get through, and which error is flagged.
  function automatic void model_frame(input int len, input int tlast_at,
                                      output int n, output bit early, output bit miss);
    early = (tlast_at != 0) && (tlast_at < len);
    n     = early ? tlast_at : len;
    miss  = !early && (tlast_at != len);
  endfunction

  task automatic run_frame(input string tag, input int len, input int tlast_at,
                           input int vpct, input int rpct,
                           input int exp_n, input bit exp_early, input bit exp_miss);
    logic [DW-1:0] data[$];
    logic [DW-1:0] hold_data = '0;
    int sent = 0, popped = 0, occ = 0, cyc = 0;
    bit last_prev = 1'b0, hold_prev = 1'b0, done_seen = 1'b0, push, pop;
    for (int i = 0; i < len; i++) data.push_back(DW'($urandom));
    start(len);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    while (!done_seen && cyc < 400) begin
      s_if.tvalid  = (sent < len) && (int'($urandom_range(99)) < vpct);
      s_if.tdata   = (sent < len) ? data[sent] : '0;
      s_if.tlast   = (sent + 1 == tlast_at);
      ss_if.tready = (int'($urandom_range(99)) < rpct);
      @(negedge clk);
      check({tag, "_level"}, 64'(level), 64'(occ));
      check({tag, "_done_timing"}, 64'(frame_done), 64'(last_prev));
      if (hold_prev) begin
        check({tag, "_hold_valid"}, 64'(ss_if.tvalid), 64'd1);
        check({tag, "_hold_data"},  64'(ss_if.tdata),  64'(hold_data));
      end
      push = s_if.tvalid && s_if.tready;
      pop  = ss_if.tvalid && ss_if.tready;
      if (pop) begin
        if (popped < exp_n) begin
          check({tag, "_data"}, 64'(ss_if.tdata), 64'(data[popped]));
          check({tag, "_last"}, 64'(ss_if.tlast), 64'(popped == exp_n - 1));
        end else begin
          check({tag, "_extra_pop"}, 64'(popped), 64'(exp_n));
        end
        popped++;
      end
      done_seen = frame_done;
      last_prev = pop && ss_if.tlast;
      hold_prev = ss_if.tvalid && !ss_if.tready;
      hold_data = ss_if.tdata;
      if (push) sent++;
      occ += int'(push) - int'(pop);
      step();
      cyc++;
    end
    s_if.tvalid  = 1'b0;
    s_if.tlast   = 1'b0;
    ss_if.tready = 1'b0;
    check({tag, "_done_seen"}, 64'(done_seen), 64'd1);
    check({tag, "_accepted"},  64'(sent),   64'(exp_n));
    check({tag, "_delivered"}, 64'(popped), 64'(exp_n));
    check({tag, "_err_early"}, 64'(err_early_last),   64'(exp_early));
    check({tag, "_err_miss"},  64'(err_missing_last), 64'(exp_miss));
    check({tag, "_busy_end"},  64'(busy),  64'd0);
    check({tag, "_level_end"}, 64'(level), 64'd0);
  endtask

  typedef struct {
    int len;
    int tlast_at;
    int vpct;
    int rpct;
    int exp_n;
    bit exp_early;
    bit exp_miss;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[8];
    bit          p;
    int          sent, base, len, tl, r, n;
    bit          e, m;
    logic [DW:0] exp_w;

    vecs[0] = '{4,  4,  100, 100, 4,  1'b0, 1'b0};
    vecs[1] = '{5,  3,  100, 100, 3,  1'b1, 1'b0};
    vecs[2] = '{3,  0,  100, 100, 3,  1'b0, 1'b1};
    vecs[3] = '{1,  1,  100, 100, 1,  1'b0, 1'b0};
    vecs[4] = '{1,  0,  100, 100, 1,  1'b0, 1'b1};
    vecs[5] = '{6,  1,  100, 60,  1,  1'b1, 1'b0};
    vecs[6] = '{12, 12, 100, 20,  12, 1'b0, 1'b0};
    vecs[7] = '{9,  9,  50,  100, 9,  1'b0, 1'b0};

    s_if.tvalid  = 1'b0;
    s_if.tdata   = '0;
    s_if.tlast   = 1'b0;
    ss_if.tready = 1'b0;
    ap_start     = 1'b0;
    data_length  = '0;
    rst          = 1'b1;
    step();
    step();
    check_reset_state("por");
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].len, vecs[i].tlast_at, vecs[i].vpct,
                vecs[i].rpct, vecs[i].exp_n, vecs[i].exp_early, vecs[i].exp_miss);

    // Fill the FIFO with the sink stalled, then drain.
    mon_q.delete();
    base = done_cnt;
    sent = 0;
    start(10);
    for (int i = 0; i < 12; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 32'h100 + 32'(sent);
      s_if.tlast  = (sent == 9);
      step_push(p);
      if (p) sent++;
    end
    check("fill_pushed",  64'(sent),         64'd8);
    check("fill_level",   64'(level),        64'd8);
    check("fill_tready",  64'(s_if.tready),  64'd0);
    check("fill_tvalid",  64'(ss_if.tvalid), 64'd1);
    check("fill_head",    64'(ss_if.tdata),  64'h100);
    ss_if.tready = 1'b1;
    @(negedge clk);
    check("fill_no_same_cycle_relief", 64'(s_if.tready), 64'd0);
    @(posedge clk); #1;
    for (int c = 0; c < 60 && sent < 10; c++) begin
      s_if.tdata = 32'h100 + 32'(sent);
      s_if.tlast = (sent == 9);
      step_push(p);
      if (p) sent++;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    wait_done("fill", 60, base);
    check("fill_count", 64'(mon_q.size()), 64'd10);
    for (int i = 0; i < 10 && i < mon_q.size(); i++) begin
      exp_w = {(i == 9), 32'(32'h100 + i)};
      check($sformatf("fill_word%0d", i), 64'(mon_q[i]), 64'(exp_w));
    end
    check("fill_level_end", 64'(level), 64'd0);
    ss_if.tready = 1'b0;

    // Zero-length frame, then an ap_start pulse during STREAM that must be ignored.
    mon_q.delete();
    ss_if.tready = 1'b1;
    start(0);
    check("zero_done",   64'(frame_done),   64'd1);
    check("zero_tvalid", 64'(ss_if.tvalid), 64'd0);
    check("zero_busy",   64'(busy),         64'd0);
    step();
    check("zero_done_pulse", 64'(frame_done), 64'd0);
    base = done_cnt;
    start(3);
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'h51;
    s_if.tlast  = 1'b0;
    step_push(p);
    ap_start    = 1'b1;
    data_length = 32'd1;
    s_if.tdata  = 32'h52;
    step_push(p);
    ap_start    = 1'b0;
    s_if.tdata  = 32'h53;
    s_if.tlast  = 1'b1;
    step_push(p);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    wait_done("restart", 20, base);
    check("restart_count", 64'(mon_q.size()), 64'd3);
    if (mon_q.size() == 3) begin
      check("restart_w0", 64'(mon_q[0]), 64'({1'b0, 32'h51}));
      check("restart_w1", 64'(mon_q[1]), 64'({1'b0, 32'h52}));
      check("restart_w2", 64'(mon_q[2]), 64'({1'b1, 32'h53}));
    end
    check("restart_err_miss",  64'(err_missing_last), 64'd0);
    check("restart_err_early", 64'(err_early_last),   64'd0);
    ss_if.tready = 1'b0;

    // Reset in the middle of a frame with five words queued.
    sent = 0;
    start(10);
    for (int c = 0; c < 20 && sent < 5; c++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 32'hA0 + 32'(sent);
      step_push(p);
      if (p) sent++;
    end
    s_if.tvalid = 1'b0;
    check("midrst_level", 64'(level), 64'd5);
    check("midrst_busy",  64'(busy),  64'd1);
    base = done_cnt;
    rst  = 1'b1;
    step();
    check_reset_state("midrst");
    rst = 1'b0;
    for (int c = 0; c < 4; c++) step();
    check("midrst_no_done", 64'(done_cnt - base), 64'd0);
    check("midrst_empty",   64'(ss_if.tvalid),    64'd0);

    // Seven stalled cycles with data queued.
    base = done_cnt;
    start(2);
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'h61;
    s_if.tlast  = 1'b0;
    step();
    s_if.tdata  = 32'h62;
    s_if.tlast  = 1'b1;
    for (int c = 0; c < 7; c++) begin
      step();
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
    end
    check("stall_cnt",   64'(stall_cnt), 64'(EXP_STALL));
    check("stall_level", 64'(level),     64'd2);
    ss_if.tready = 1'b1;
    wait_done("stall", 20, base);
    check("stall_cnt_hold", 64'(stall_cnt), 64'(EXP_STALL));
    start(0);
    check("stall_clear", 64'(stall_cnt), 64'd0);
    step();
    ss_if.tready = 1'b0;

    for (int f = 0; f < 25; f++) begin
      len = int'($urandom_range(12, 1));
      r   = int'($urandom_range(3));
      tl  = (r < 2) ? len : ((r == 2) ? 0 : int'($urandom_range(len, 1)));
      model_frame(len, tl, n, e, m);
      run_frame($sformatf("rnd%0d", f), len, tl, int'($urandom_range(100, 30)),
                int'($urandom_range(100, 30)), n, e, m);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
